slc3_mem_bridge: RTL
====================

Name: slc3_mem_bridge

Overview:
- Memory-access stage directly downstream of the SLC-3 control FSM and datapath.
- Converts the CPU-side MAR/MDR address, data and the Mem_OE/Mem_WE strobes into timed accesses to a synchronous BRAM with a registered output.
- Decodes one memory-mapped I/O address: a read returns the switches, a write loads the hex-display register.
- Returns read data toward the MDR with a one-cycle Mem_Ready completion pulse, so the control FSM can wait on it instead of counting fixed wait states.

Parameters:
- READ_LAT, 2, BRAM read latency in cycles from address/enable to valid bram_dout (range 1..7).
- IO_ADDR, 16'hFFFF, address decoded as I/O instead of BRAM.
- ADDR_W, 16, CPU address width; BRAM uses all bits.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Mem_OE  in  1  read request from control FSM (level).
- Mem_WE  in  1  write request from control FSM (level).
- ADDR  in  16  access address (from MAR).
- Data_from_CPU  in  16  write data (from MDR).
- Data_to_CPU  out  16  read data toward MDR input mux.
- Mem_Ready  out  1  one-cycle completion pulse.
- bram_addr  out  16  BRAM address.
- bram_din  out  16  BRAM write data.
- bram_dout  in  16  BRAM read data (valid READ_LAT cycles after enable).
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- SW  in  16  asynchronous switch inputs.
- hex_out  out  16  hex-display register.

Behaviour:
- Reset (asynchronous): state IDLE, Data_to_CPU=0, Mem_Ready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, hex_out=0, wait counter=0, both synchronizer stages=0.
- SW passes through a 2-flop synchronizer; I/O reads return the second stage.
- States: IDLE, RD_WAIT, DONE, HOLD.
- IDLE, request = Mem_OE|Mem_WE. On the cycle a request is seen, latch ADDR and Data_from_CPU, then:
  - Mem_WE=1 (has priority if Mem_OE is also 1), ADDR != IO_ADDR: bram_en=1, bram_we=1 for exactly that one cycle, bram_din=Data_from_CPU; go to DONE.
  - Mem_WE=1, ADDR == IO_ADDR: hex_out <= Data_from_CPU at that edge; no BRAM access; go to DONE.
  - Mem_OE only, ADDR == IO_ADDR: Data_to_CPU <= synchronized SW; go to DONE.
  - Mem_OE only, BRAM address: bram_en=1, counter <= READ_LAT-1; go to RD_WAIT.
- RD_WAIT: bram_en held at 1 and bram_addr held at the latched address. The counter decrements each cycle. When the counter is 0, Data_to_CPU <= bram_dout and the state goes to DONE.
- DONE: Mem_Ready=1 for exactly one cycle; go to HOLD.
- HOLD: no new access until Mem_OE=0 and Mem_WE=0 are sampled together, then IDLE. This prevents retriggering while the FSM still holds the strobe.
- Latency from the request cycle to the Mem_Ready cycle:
  - BRAM read: READ_LAT+1 cycles (3 at default).
  - Any write, or an I/O read: 1 cycle.
- Data_to_CPU holds its value until the next completed read; writes never change it.
- bram_addr and bram_din hold their last values when idle. bram_en and bram_we are 0 outside the cycles stated above.
- A strobe that drops during RD_WAIT does not abort the access; it completes and the HOLD exit follows immediately.
- Reset asserted mid-access returns to IDLE at once. No BRAM write may occur in the reset cycle.
- Address wrap is not applicable (full 16-bit decode); address 16'hFFFE is ordinary BRAM.

Test Plan:
- BRAM read: preload BRAM[16'h0010]=16'h1234. Hold Mem_OE=1 with ADDR=16'h0010 from cycle 0 -> bram_en high in cycles 0-2, Mem_Ready pulse in cycle 3, Data_to_CPU=16'h1234, no second pulse while Mem_OE stays high.
- BRAM write: Mem_WE=1, ADDR=16'h0020, Data_from_CPU=16'hBEEF -> single-cycle bram_we at cycle 0, Mem_Ready at cycle 1; a subsequent read of 16'h0020 returns 16'hBEEF.
- I/O: SW=16'h00A5 stable; Mem_OE at ADDR=16'hFFFF -> Data_to_CPU=16'h00A5 with Mem_Ready at cycle 1, bram_en never asserted. Mem_WE at 16'hFFFF with data 16'h0042 -> hex_out=16'h0042, bram_we stays 0.
- Simultaneous strobes: Mem_OE=Mem_WE=1 at 16'h0030 with data 16'h5555 -> a write occurs and Data_to_CPU is unchanged.
- Reset mid-read: assert Reset in cycle 1 of a BRAM read -> all outputs return to reset values at once, no Mem_Ready. After release with strobes low, a new read completes normally.
- Strobe dropped early: Mem_OE high only in cycle 0 -> Mem_Ready still pulses in cycle 3, and the block is back in IDLE in cycle 5.

Source files
------------

// File: rtl/slc3_mem_bridge.sv
// Memory-access bridge between the SLC-3 control FSM and a registered-output BRAM.
// It also decodes one I/O address: reads return the switches and writes load the hex display.
module slc3_mem_bridge #(
  parameter int                 ADDR_W   = 16,
  parameter int                 READ_LAT = 2,
  parameter logic [ADDR_W-1:0]  IO_ADDR  = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_from_CPU,
  output logic [15:0]       Data_to_CPU,
  output logic              Mem_Ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_din,
  input  logic [15:0]       bram_dout,
  output logic              bram_en,
  output logic              bram_we,
  input  logic [15:0]       SW,
  output logic [15:0]       hex_out
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE, HOLD} state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       din_q;
  logic [15:0]       sw_p0, sw_p1;
  logic              req, is_io;

  assign req   = Mem_OE | Mem_WE;
  assign is_io = (ADDR == IO_ADDR);

  // The request cycle drives the BRAM straight from the CPU inputs; later cycles use the latched copies.
  always_comb begin
    state_d   = state_q;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = addr_q;
    bram_din  = din_q;
    Mem_Ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          bram_addr = ADDR;
          bram_din  = Data_from_CPU;
          if (Mem_WE) begin
            bram_en = !is_io;
            bram_we = !is_io;
            state_d = DONE;
          end else if (is_io) begin
            state_d = DONE;
          end else begin
            bram_en = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        bram_en = 1'b1;
        if (cnt_q == 3'd0) state_d = DONE;
      end
      DONE: begin
        Mem_Ready = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset blocks any BRAM strobe even before the next edge.
    if (Reset) begin
      state_d   = IDLE;
      bram_en   = 1'b0;
      bram_we   = 1'b0;
      Mem_Ready = 1'b0;
      bram_addr = addr_q;
      bram_din  = din_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      din_q       <= 16'h0000;
      Data_to_CPU <= 16'h0000;
      hex_out     <= 16'h0000;
      sw_p0       <= 16'h0000;
      sw_p1       <= 16'h0000;
    end else begin
      state_q <= state_d;
      sw_p0   <= SW;
      sw_p1   <= sw_p0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q <= ADDR;
            din_q  <= Data_from_CPU;
            if (Mem_WE) begin
              if (is_io) hex_out <= Data_from_CPU;
            end else if (is_io) begin
              Data_to_CPU <= sw_p1;
            end else begin
              cnt_q <= CNT_INIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) Data_to_CPU <= bram_dout;
          else               cnt_q       <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
